// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder over NUM_REGS byte-writable 32-bit registers, mirrored onto regs_o.
// Latency: write commits one edge after both AW and W are held; read data valid one edge after AR.
// Backpressure: one AW and one W are buffered while B stalls; ARREADY drops while R is outstanding.
module axi_lite_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 12
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o
);
    localparam int         DW          = C_S_AXI_DATA_WIDTH;
    localparam int         IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int         STRB_W      = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Packed so that reg k lands at bits [32k+31:32k] of regs_o without extra wiring.
    logic [NUM_REGS-1:0][DW-1:0] regs;

    logic              rst_done;
    logic              aw_full;
    logic              w_full;
    logic [IDX_W-1:0]  aw_idx;
    logic [DW-1:0]     w_data;
    logic [STRB_W-1:0] w_strb;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              rvalid;
    logic [1:0]        rresp;
    logic [DW-1:0]     rdata;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic              aw_in_range;
    logic              ar_in_range;
    logic [IDX_W-1:0]  ar_idx;
    logic [DW-1:0]     rd_mux;
    logic              unused_ok;

    assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_in_range = ({1'b0, aw_idx} < (IDX_W+1)'(NUM_REGS));
    assign ar_in_range = ({1'b0, ar_idx} < (IDX_W+1)'(NUM_REGS));

    assign S_AXI_AWREADY = rst_done & ~aw_full;
    assign S_AXI_WREADY  = rst_done & ~w_full;
    assign S_AXI_ARREADY = rst_done & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign regs_o        = regs;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_full & w_full & (~bvalid | S_AXI_BREADY);

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Out-of-range indices match no entry and fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) rd_mux = regs[k];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (aw_idx == IDX_W'(k)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb[b]) regs[k][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rst_done <= 1'b0;
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            rst_done <= 1'b1;
            // Capture and commit never coincide: a full slot holds READY low.
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // rd_mux samples pre-commit flops, so a same-edge write is not yet visible.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
            rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end
endmodule
